isq_issue_select: RTL and testbench

ISQ_ISSUE_SELECT -- requirements
Module: isq_issue_select

---
 rtl/isq_issue_select.sv | 98 +++++++++
 tb/tb_isq_issue_select.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/isq_issue_select.sv
// Issue-queue select: picks the oldest ready entry (age relative to oldest_index)
// and moves it into a single issue register with valid/ready handshake.
module isq_issue_select #(
  parameter int NUM_ENTRIES = 8,
  parameter int DATA_WIDTH  = 248,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_ENTRIES-1:0]            entry_ready,
  input  logic [NUM_ENTRIES*INDEX_WIDTH-1:0] entry_index,
  input  logic [NUM_ENTRIES*DATA_WIDTH-1:0]  entry_data,
  input  logic [INDEX_WIDTH-1:0]            oldest_index,
  input  logic                              flush,
  output logic [NUM_ENTRIES-1:0]            clear_entry,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  output logic [DATA_WIDTH-1:0]             issue_data,
  output logic [INDEX_WIDTH-1:0]            issue_index,
  output logic [31:0]                       issue_count
);

  logic                   win_found;
  logic [NUM_ENTRIES-1:0] win_onehot;
  logic [INDEX_WIDTH-1:0] win_age;
  logic [INDEX_WIDTH-1:0] win_index;
  logic [DATA_WIDTH-1:0]  win_data;
  logic [INDEX_WIDTH-1:0] age;

  logic                   reg_free;
  logic                   sel_fire;

  logic                   valid_d, valid_q;
  logic [DATA_WIDTH-1:0]  data_d, data_q;
  logic [INDEX_WIDTH-1:0] index_d, index_q;
  logic [31:0]            count_d, count_q;

  // Ascending scan with strict compare keeps the lowest entry number on equal age.
  always_comb begin
    win_found  = 1'b0;
    win_onehot = '0;
    win_age    = '0;
    win_index  = '0;
    win_data   = '0;
    age        = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      age = entry_index[i*INDEX_WIDTH +: INDEX_WIDTH] - oldest_index;
      if (entry_ready[i] && (!win_found || (age < win_age))) begin
        win_found  = 1'b1;
        win_onehot = '0;
        win_onehot[i] = 1'b1;
        win_age    = age;
        win_index  = entry_index[i*INDEX_WIDTH +: INDEX_WIDTH];
        win_data   = entry_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign reg_free    = !valid_q || issue_ready;
  assign sel_fire    = !reset && !flush && reg_free && win_found;
  assign clear_entry = sel_fire ? win_onehot : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    count_d = count_q + 32'(sel_fire);
    if (flush) begin
      valid_d = 1'b0;
    end else if (sel_fire) begin
      valid_d = 1'b1;
      data_d  = win_data;
      index_d = win_index;
    end else if (reg_free) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      count_q <= count_d;
    end
  end

  assign issue_valid = valid_q;
  assign issue_data  = data_q;
  assign issue_index = index_q;
  assign issue_count = count_q;

endmodule

// File: tb/tb_isq_issue_select.sv
// Randomized and directed bench for isq_issue_select against an age-key reference model.
module tb_isq_issue_select;

  localparam int NE = 8;
  localparam int DW = 248;
  localparam int IW = 4;
  localparam int MODV = 1 << IW;

  logic               clock;
  logic               reset;
  logic [NE-1:0]      entry_ready;
  logic [NE*IW-1:0]   entry_index;
  logic [NE*DW-1:0]   entry_data;
  logic [IW-1:0]      oldest_index;
  logic               flush;
  logic [NE-1:0]      clear_entry;
  logic               issue_valid;
  logic               issue_ready;
  logic [DW-1:0]      issue_data;
  logic [IW-1:0]      issue_index;
  logic [31:0]        issue_count;

  logic               m_valid;
  logic [DW-1:0]      m_data;
  logic [IW-1:0]      m_index;
  logic [31:0]        m_count;

  int n_checks = 0;
  int n_fail   = 0;

  isq_issue_select #(.NUM_ENTRIES(NE), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .clock        (clock),
    .reset        (reset),
    .entry_ready  (entry_ready),
    .entry_index  (entry_index),
    .entry_data   (entry_data),
    .oldest_index (oldest_index),
    .flush        (flush),
    .clear_entry  (clear_entry),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_data   (issue_data),
    .issue_index  (issue_index),
    .issue_count  (issue_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Oldest ready entry = smallest key age*NE + entry, age taken modulo 2^IW.
  function automatic int model_winner();
    int best_key = -1;
    int best     = -1;
    for (int i = 0; i < NE; i++) begin
      if (entry_ready[i]) begin
        int a   = (int'(entry_index[i*IW +: IW]) - int'(oldest_index) + MODV) % MODV;
        int key = a * NE + i;
        if (best_key < 0 || key < best_key) begin
          best_key = key;
          best     = i;
        end
      end
    end
    return best;
  endfunction

  task automatic set_idx(input int i, input int v);
    entry_index[i*IW +: IW] = IW'(v);
  endtask

  task automatic rand_data();
    for (int k = 0; k < (NE*DW)/32; k++) entry_data[k*32 +: 32] = $urandom();
  endtask

  task automatic rand_entries();
    entry_ready  = NE'($urandom()) & NE'($urandom());
    if ($urandom_range(0, 3) == 0) entry_ready = '0;
    for (int i = 0; i < NE; i++) set_idx(i, int'($urandom_range(0, MODV-1)));
    oldest_index = IW'($urandom_range(0, MODV-1));
    rand_data();
  endtask

  // Called at a negedge with inputs already driven; checks, then advances the model over the posedge.
  task automatic cycle();
    int      w;
    logic    free;
    logic    fire;
    logic [NE-1:0] exp_clear;
    w    = model_winner();
    free = !m_valid || issue_ready;
    fire = !reset && !flush && free && (w >= 0);
    exp_clear = '0;
    if (fire) exp_clear[w] = 1'b1;
    #1;
    check("clear_entry", 256'(clear_entry), 256'(exp_clear));
    check("issue_valid", 256'(issue_valid), 256'(m_valid));
    check("issue_index", 256'(issue_index), 256'(m_index));
    check("issue_data",  256'(issue_data),  256'(m_data));
    check("issue_count", 256'(issue_count), 256'(m_count));
    @(posedge clock);
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_index = '0; m_count = '0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (fire) begin
      m_valid = 1'b1;
      m_data  = entry_data[w*DW +: DW];
      m_index = entry_index[w*IW +: IW];
      m_count = m_count + 32'd1;
    end else if (free) begin
      m_valid = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic drain();
    entry_ready = '0; issue_ready = 1'b1; flush = 1'b0;
    cycle();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    entry_ready = '0; entry_index = '0; entry_data = '0; oldest_index = '0;
    m_valid = 1'b0; m_data = '0; m_index = '0; m_count = '0;
    @(posedge clock);
    @(negedge clock);
    // Reset held with live candidates: no dequeue allowed.
    rand_entries(); entry_ready = '1; issue_ready = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    drain();

    // Basic select from empty register.
    entry_ready = 8'b0000_1010; oldest_index = 4'd0; issue_ready = 1'b0;
    set_idx(1, 5); set_idx(3, 2); rand_data();
    #1 check("r34_clear", 256'(clear_entry), 256'(8'b0000_1000));
    cycle();
    check("r34_valid", 256'(issue_valid), 256'(1'b1));
    check("r34_index", 256'(issue_index), 256'(4'd2));
    check("r34_count", 256'(issue_count), 256'(32'd1));
    drain(); drain();

    // Age wraps around the index space.
    entry_ready = 8'b0000_0101; oldest_index = 4'd14;
    set_idx(0, 1); set_idx(2, 15); rand_data();
    #1 check("wrap_clear", 256'(clear_entry), 256'(8'b0000_0100));
    cycle();
    check("wrap_index", 256'(issue_index), 256'(4'd15));
    drain(); drain();

    // Equal age resolves to lowest entry.
    entry_ready = 8'b0101_0000; oldest_index = 4'd3;
    set_idx(4, 7); set_idx(6, 7); rand_data();
    #1 check("tie_clear", 256'(clear_entry), 256'(8'b0001_0000));
    cycle();
    drain(); drain();

    // Stall three cycles, then release with a candidate waiting.
    rand_entries(); entry_ready = 8'b1111_1111; issue_ready = 1'b1;
    cycle();
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      entry_ready = 8'b0110_0110;
      cycle();
    end
    issue_ready = 1'b1;
    #1 check("stall_release_clear_nz", 256'(clear_entry != '0), 256'(1'b1));
    cycle();
    check("stall_nobubble", 256'(issue_valid), 256'(1'b1));

    // Flush with held instruction and ready entries.
    issue_ready = 1'b0; flush = 1'b1; entry_ready = '1;
    cycle();
    check("flush_valid", 256'(issue_valid), 256'(1'b0));
    flush = 1'b0;
    drain();

    // Counter wrap, using a forced preload.
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    m_count = 32'hFFFF_FFFF;
    rand_entries(); entry_ready = 8'b0000_0001; issue_ready = 1'b0;
    cycle();
    check("count_wrap", 256'(issue_count), 256'(32'd0));
    // Reset during a stall.
    issue_ready = 1'b0; entry_ready = '1; reset = 1'b1;
    cycle();
    check("rst_stall_valid", 256'(issue_valid), 256'(1'b0));
    check("rst_stall_count", 256'(issue_count), 256'(32'd0));
    reset = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      rand_entries();
      issue_ready = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 15) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
